// File: rtl/opti_fix_pkg.sv
// Shared fixed-point helpers: rounding-mode encodings, Qm.n range limits and
// legality checks used when the multiplier is elaborated.
package opti_fix_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int RND_EVEN    = 2;

  function automatic longint q_max(input int dw);
    return (longint'(1) << (dw - 1)) - longint'(1);
  endfunction

  function automatic longint q_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

  function automatic bit fmt_ok(input int dw, input int fw);
    return (dw % 2 == 0) && (dw >= 8) && (dw <= 32) && (fw >= 0) && (fw < dw);
  endfunction

endpackage

// File: rtl/opti_round_sat.sv
// Combinational round/saturate of an exact 2*DW-bit product back to DW bits.
// One guard bit above the product keeps the rounding increment from wrapping.
module opti_round_sat
  import opti_fix_pkg::*;
#(
  parameter int DW       = 24,
  parameter int FW       = 22,
  parameter int RND_MODE = RND_HALF_UP,
  parameter int SAT_EN   = 1
) (
  input  logic [2*DW-1:0] p,
  output logic [DW-1:0]   res,
  output logic            ovf
);

  localparam int PW = 2*DW + 1;
  localparam int HS = (FW > 0) ? FW - 1 : 0;
  localparam logic signed [PW-1:0] ONE   = PW'(1);
  localparam logic signed [PW-1:0] HALF  = (FW > 0) ? (ONE <<< HS) : '0;
  localparam logic        [PW-1:0] FMASK = PW'((ONE <<< FW) - ONE);
  localparam logic signed [PW-1:0] RMAX  = (ONE <<< (DW - 1)) - ONE;
  localparam logic signed [PW-1:0] RMIN  = -(ONE <<< (DW - 1));
  localparam logic [DW-1:0] SMAX = DW'(q_max(DW));
  localparam logic [DW-1:0] SMIN = DW'(q_min(DW));

  logic signed [PW-1:0] pe, inc, rsum, r;
  logic        [PW-1:0] frac;
  logic                 tie;

  always_comb begin
    pe   = signed'({p[2*DW-1], p});
    frac = pe & FMASK;
    tie  = (frac == HALF);
    inc  = '0;
    // Half-to-even only suppresses the increment on an exact tie with an even kept LSB.
    if (FW > 0) begin
      if (RND_MODE == RND_HALF_UP) inc = HALF;
      else if (RND_MODE == RND_EVEN && !(tie && !pe[FW])) inc = HALF;
    end
    rsum = pe + inc;
    r    = rsum >>> FW;
    ovf  = (r > RMAX) || (r < RMIN);
    res  = r[DW-1:0];
    if (SAT_EN != 0 && ovf) res = r[PW-1] ? SMIN : SMAX;
  end

endmodule

// File: rtl/opti_booth_mult_pipe.sv
// Signed Qm.n radix-4 Booth multiplier, one partial product per stage, latency DW/2+2.
// Whole pipe stalls when the output is held (in_ready = !out_valid | out_ready).
module opti_booth_mult_pipe
  import opti_fix_pkg::*;
#(
  parameter int DW       = 24,
  parameter int FW       = 22,
  parameter int RND_MODE = RND_HALF_UP,
  parameter int SAT_EN   = 1,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int NG = DW / 2;
  localparam int SW = 2*DW + 2;

  if (!fmt_ok(DW, FW)) begin : g_bad_fmt
    $error("opti_booth_mult_pipe: DW must be even in 8..32 and FW in 0..DW-1");
  end
  if (RND_MODE < RND_TRUNC || RND_MODE > RND_EVEN) begin : g_bad_rnd
    $error("opti_booth_mult_pipe: unsupported RND_MODE");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("opti_booth_mult_pipe: TAG_W must be at least 1");
  end

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic        [DW-1:0]    a_q   [0:NG-1];
  logic        [DW-1:0]    b_q   [0:NG-1];
  logic        [TAG_W-1:0] tag_q [0:NG];
  logic                    vld_q [0:NG];
  logic signed [SW-1:0]    acc_q [1:NG];
  logic signed [SW-1:0]    pp    [1:NG];

  // Stage k consumes Booth triplet k of a (a[-1] = 0) against b delayed k-1 times.
  for (genvar k = 1; k <= NG; k++) begin : g_booth
    logic        [2:0]    trip;
    logic signed [SW-1:0] bx, sel;
    if (k == 1) begin : g_lsb
      assign trip = {a_q[0][1:0], 1'b0};
    end else begin : g_grp
      assign trip = a_q[k-1][2*k-1 -: 3];
    end
    always_comb begin
      bx = SW'(signed'(b_q[k-1]));
      case (trip)
        3'b001, 3'b010: sel = bx;
        3'b011:         sel = bx <<< 1;
        3'b100:         sel = -(bx <<< 1);
        3'b101, 3'b110: sel = -bx;
        default:        sel = '0;
      endcase
    end
    assign pp[k] = sel <<< (2*(k-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NG; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
      for (int i = 0; i < NG; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int i = 1; i <= NG; i++) acc_q[i] <= '0;
    end else begin
      // Flush overrides the stall so in-flight beats die even while the output is held.
      if (clr)     vld_q[0] <= 1'b0;
      else if (en) vld_q[0] <= in_valid;
      for (int i = 1; i <= NG; i++) begin
        if (clr)     vld_q[i] <= 1'b0;
        else if (en) vld_q[i] <= vld_q[i-1];
      end
      if (en) begin
        a_q[0]   <= in_a;
        b_q[0]   <= in_b;
        tag_q[0] <= in_tag;
        for (int i = 1; i < NG; i++) begin
          a_q[i] <= a_q[i-1];
          b_q[i] <= b_q[i-1];
        end
        for (int i = 1; i <= NG; i++) tag_q[i] <= tag_q[i-1];
        acc_q[1] <= pp[1];
        for (int i = 2; i <= NG; i++) acc_q[i] <= acc_q[i-1] + pp[i];
      end
    end
  end

  logic [DW-1:0] rs_p;
  logic          rs_ovf;

  opti_round_sat #(
    .DW(DW), .FW(FW), .RND_MODE(RND_MODE), .SAT_EN(SAT_EN)
  ) u_round_sat (
    .p   (acc_q[NG][2*DW-1:0]),
    .res (rs_p),
    .ovf (rs_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (clr)     out_valid <= 1'b0;
      else if (en) out_valid <= vld_q[NG];
      if (en) begin
        out_p   <= rs_p;
        out_tag <= tag_q[NG];
        out_ovf <= rs_ovf;
      end
    end
  end

endmodule

// File: tb/tb_opti_booth_mult_pipe.sv
// Scoreboard bench: stimulus pushes model results, monitors pop on each output beat.
module tb_opti_booth_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] p;
    logic        ovf;
    logic [3:0]  tag;
    bit          lat;
    int          acc;
  } ex_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // Exact product, then floor division by 2^fw with the remainder deciding the rounding.
  function automatic logic [64:0] ref_mult(input int dw, input int fw, input int mode,
                                           input bit sat, input logic [63:0] a,
                                           input logic [63:0] b);
    logic signed [63:0]  ta, tb2;
    logic signed [127:0] pr, sc, q, rem, half, r, mx, mn;
    logic                ovf;
    ta  = a << (64 - dw);
    ta  = ta >>> (64 - dw);
    tb2 = b << (64 - dw);
    tb2 = tb2 >>> (64 - dw);
    pr  = 128'(ta) * 128'(tb2);
    sc  = 128'sd1 <<< fw;
    q   = pr >>> fw;
    rem = pr - q * sc;
    half = sc >>> 1;
    if (fw == 0) r = pr;
    else begin
      case (mode)
        0:       r = q;
        1:       r = (rem >= half) ? q + 1 : q;
        default: r = (rem > half || (rem == half && q[0])) ? q + 1 : q;
      endcase
    end
    mx  = (128'sd1 <<< (dw - 1)) - 1;
    mn  = -(128'sd1 <<< (dw - 1));
    ovf = (r > mx) || (r < mn);
    if (sat && ovf) r = (r > mx) ? mx : mn;
    return {ovf, r[63:0] & ((64'd1 << dw) - 64'd1)};
  endfunction

  // ---------------- main DUT: Q2.22, half-up, saturating ----------------
  logic        m_clr, m_vld, m_rdy_in, m_ovld, m_ordy, m_ovf;
  logic [23:0] m_a, m_b, m_p;
  logic [3:0]  m_tag, m_otag;
  ex_t         mq[$];
  int          rdy_mode = 0;

  opti_booth_mult_pipe #(
    .DW(24), .FW(22), .RND_MODE(1), .SAT_EN(1), .TAG_W(4)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .clr(m_clr),
    .in_valid(m_vld), .in_ready(m_rdy_in), .in_a(m_a), .in_b(m_b), .in_tag(m_tag),
    .out_valid(m_ovld), .out_ready(m_ordy), .out_p(m_p), .out_tag(m_otag), .out_ovf(m_ovf)
  );

  initial begin
    m_ordy = 1'b1;
    forever begin
      @(negedge clk);
      m_ordy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  logic        prev_stall = 1'b0, prev_clr = 1'b0, prev_ovf = 1'b0;
  logic [23:0] prev_p = '0;
  logic [3:0]  prev_tag = '0;

  always @(negedge clk) begin
    ex_t e;
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 64'(m_rdy_in), 64'(!(m_ovld && !m_ordy)));
      if (prev_stall && !prev_clr) begin
        chk("stall_valid", 64'(m_ovld), 64'(1));
        chk("stall_p", 64'(m_p), 64'(prev_p));
        chk("stall_tag", 64'(m_otag), 64'(prev_tag));
        chk("stall_ovf", 64'(m_ovf), 64'(prev_ovf));
      end
      if (m_ovld && m_ordy) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL main_unexpected: got beat p=%h tag=%h, want none", m_p, m_otag);
        end else begin
          e = mq.pop_front();
          chk("main_p", 64'(m_p), e.p);
          chk("main_ovf", 64'(m_ovf), 64'(e.ovf));
          chk("main_tag", 64'(m_otag), 64'(e.tag));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(14));
        end
      end
      prev_stall = m_ovld && !m_ordy;
      prev_p     = m_p;
      prev_tag   = m_otag;
      prev_ovf   = m_ovf;
      prev_clr   = m_clr;
    end
  end

  task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [3:0] tag,
                      input logic [23:0] ep, input logic eovf, input bit lat);
    int  n;
    ex_t e;
    n = 0;
    m_a = a; m_b = b; m_tag = tag; m_vld = 1'b1;
    forever begin
      #1;
      if (m_rdy_in) begin
        e.p = 64'(ep); e.ovf = eovf; e.tag = tag; e.lat = lat; e.acc = cyc;
        mq.push_back(e);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 300) begin
        total++;
        bad++;
        $display("FAIL send_timeout: tag %0d still waiting after %0d cycles, want accept", tag, n);
        break;
      end
    end
    m_vld = 1'b0;
  endtask

  task automatic send_m(input logic [23:0] a, input logic [23:0] b, input logic [3:0] tag,
                        input bit lat);
    logic [64:0] rv;
    rv = ref_mult(24, 22, 1, 1'b1, 64'(a), 64'(b));
    send(a, b, tag, rv[23:0], rv[64], lat);
  endtask

  // ---------------- auxiliary configurations, always-ready ----------------
  localparam int NCFG = 9;
  localparam int CDW  [NCFG] = '{24, 24, 24, 8, 8, 8, 32, 32, 32};
  localparam int CFW  [NCFG] = '{22, 22, 22, 4, 4, 4, 30, 30, 30};
  localparam int CRM  [NCFG] = '{0, 2, 1, 0, 1, 2, 0, 1, 2};
  localparam int CSAT [NCFG] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};

  logic        x_vld;
  logic [31:0] x_a, x_b;
  logic [3:0]  x_tag;
  int          aux_pending = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_aux
    localparam int D = CDW[g];
    logic         rdy, ovld, ovf;
    logic [D-1:0] p;
    logic [3:0]   otag;
    ex_t          q[$];

    opti_booth_mult_pipe #(
      .DW(D), .FW(CFW[g]), .RND_MODE(CRM[g]), .SAT_EN(CSAT[g]), .TAG_W(4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(1'b0),
      .in_valid(x_vld), .in_ready(rdy), .in_a(x_a[D-1:0]), .in_b(x_b[D-1:0]), .in_tag(x_tag),
      .out_valid(ovld), .out_ready(1'b1), .out_p(p), .out_tag(otag), .out_ovf(ovf)
    );

    always @(negedge clk) begin
      ex_t         e;
      logic [64:0] rv;
      #1;
      if (rst_n) begin
        if (ovld) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL aux%0d_unexpected: got beat p=%h, want none", g, p);
          end else begin
            e = q.pop_front();
            aux_pending--;
            chk($sformatf("aux%0d_p", g), 64'(p), e.p);
            chk($sformatf("aux%0d_ovf", g), 64'(ovf), 64'(e.ovf));
            chk($sformatf("aux%0d_tag", g), 64'(otag), 64'(e.tag));
          end
        end
        if (x_vld && rdy) begin
          rv = ref_mult(D, CFW[g], CRM[g], CSAT[g] != 0, 64'(x_a), 64'(x_b));
          e.p = rv[63:0]; e.ovf = rv[64]; e.tag = x_tag; e.lat = 1'b0; e.acc = cyc;
          q.push_back(e);
          aux_pending++;
        end
      end
    end
  end

  task automatic aux_beat(input logic [31:0] a, input logic [31:0] b);
    x_a = a; x_b = b; x_tag = x_tag + 4'd1; x_vld = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_main();
    for (int i = 0; i < 300 && mq.size() > 0; i++) @(negedge clk);
  endtask

  logic [31:0] cv [14] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80,
                           32'h7F, 32'h800000, 32'h7FFFFF, 32'h200000, 32'h400000, 32'h3,
                           32'hE00000, 32'hC0000000};

  initial begin
    rst_n = 1'b0; m_clr = 1'b0; m_vld = 1'b0; m_a = '0; m_b = '0; m_tag = '0;
    x_vld = 1'b0; x_a = '0; x_b = '0; x_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(m_ovld), 64'(0));
    chk("rst_out_p", 64'(m_p), 64'(0));
    chk("rst_out_tag", 64'(m_otag), 64'(0));
    chk("rst_out_ovf", 64'(m_ovf), 64'(0));
    chk("rst_in_ready", 64'(m_rdy_in), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Corner pairs then random operands across all auxiliary formats.
    for (int i = 0; i < 14; i++)
      for (int j = 0; j < 14; j++) aux_beat(cv[i], cv[j]);
    for (int n = 0; n < 2000; n++)
      aux_beat(32'($signed($urandom) >>> $urandom_range(0, 31)),
               32'($signed($urandom) >>> $urandom_range(0, 31)));
    x_vld = 1'b0;
    for (int i = 0; i < 100 && aux_pending > 0; i++) @(negedge clk);
    chk("aux_drain", 64'(aux_pending), 64'(0));

    // Directed vectors with fixed expected results and exact latency.
    send(24'h400000, 24'h400000, 4'h5, 24'h400000, 1'b0, 1'b1);
    send(24'h200000, 24'hE00000, 4'h6, 24'hF00000, 1'b0, 1'b1);
    send(24'h800000, 24'h800000, 4'h7, 24'h7FFFFF, 1'b1, 1'b1);
    send(24'h000001, 24'h200000, 4'h8, 24'h000001, 1'b0, 1'b1);
    send(24'h000003, 24'h200000, 4'h9, 24'h000002, 1'b0, 1'b1);
    send(24'hFFFFFF, 24'h200000, 4'hA, 24'h000000, 1'b0, 1'b1);
    drain_main();

    // Random backpressure stream.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_m(24'($urandom), 24'($urandom), 4'(i), 1'b0);
    end
    rdy_mode = 0;
    drain_main();
    chk("bp_drain", 64'(mq.size()), 64'(0));

    // Flush while the output is held.
    for (int i = 0; i < 16; i++) send_m(24'($urandom), 24'($urandom), 4'(i), 1'b0);
    rdy_mode = 2;
    @(negedge clk);
    m_clr = 1'b1; m_a = 24'h123456; m_b = 24'h0ABCDE; m_tag = 4'hF; m_vld = 1'b1;
    @(negedge clk);
    m_clr = 1'b0; m_vld = 1'b0;
    mq.delete();
    #1;
    chk("clr_out_valid", 64'(m_ovld), 64'(0));
    rdy_mode = 0;
    repeat (25) @(negedge clk);
    send_m(24'h300000, 24'hD00000, 4'h3, 1'b1);
    drain_main();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 16; i++) send_m(24'($urandom), 24'($urandom), 4'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(m_ovld), 64'(0));
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 64'(m_rdy_in), 64'(1));
    repeat (30) @(negedge clk);
    send_m(24'h5A5A5A, 24'h1F0F0F, 4'hC, 1'b1);
    drain_main();
    chk("main_drain", 64'(mq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
